dog_extrema_detect: RTL and testbench

Scale-space extremum detector placed directly downstream of the Gaussian/DoG filter bank. It consumes three adjacent DoG scale streams (below, centre, above) in raster order, one pixel per enabled clock. It builds a 3x3 window per scale and flags the centre pixel of the middle scale as a keypoint when it strictly exceeds, or strictly undercuts, all 26 neighbours and passes a contrast threshold. Each flagged pixel is emitted as a one-cycle keypoint pulse with its coordinates.

---
 rtl/dog_extrema_detect_pkg.sv | 24 ++
 rtl/dog_extrema_detect_line_window.sv | 62 ++++++
 rtl/dog_extrema_detect.sv | 203 ++++++++++++++++++++
 tb/tb_dog_extrema_detect.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dog_extrema_detect_pkg.sv
// Shared definitions for the DoG scale-space keypoint pipeline.
// Holds the default sample width and line length, the neighbour count of
// a 3x3x3 scale-space cube, and the reduction helpers that turn per-neighbour
// strict-compare bits into a single extremum decision. Later orientation and
// refinement stages reuse these helpers.
package dog_extrema_detect_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int FRAME_W_DEF = 200;

  // 9 (scale below) + 9 (scale above) + 8 (same scale, centre excluded)
  localparam int NB_N = 26;

  // True only when the centre was strictly greater than every neighbour.
  function automatic logic gt26(input logic [NB_N-1:0] gt_bits);
    return &gt_bits;
  endfunction

  // True only when the centre was strictly smaller than every neighbour.
  function automatic logic lt26(input logic [NB_N-1:0] lt_bits);
    return &lt_bits;
  endfunction

endpackage

// File: rtl/dog_extrema_detect_line_window.sv
// dog_line_window: two line buffers plus a 3x3 sliding window for one scale.
// Ports:
//   clk      - pixel clock
//   shift_en - an accepted pixel; writes the line buffers and shifts the window
//   addr     - column of the accepted pixel (line-buffer address)
//   din      - incoming sample
//   win      - 3x3 window, index r*3+c; r=0 is two rows up, c=2 newest column
// The line buffers are addressed by column, so lb0[col] always holds the
// previous row and lb1[col] the row before that; no pointer needs reset.
// Buffer and window contents are deliberately unreset: the top-level row/col
// gating guarantees stale data is never evaluated.
module dog_line_window #(
  parameter int dataW  = 8,
  parameter int frameW = 200
) (
  input  logic                        clk,
  input  logic                        shift_en,
  input  logic [$clog2(frameW)-1:0]   addr,
  input  logic [dataW-1:0]            din,
  output logic [8:0][dataW-1:0]       win
);

  logic [dataW-1:0] lb0_mem [frameW];
  logic [dataW-1:0] lb1_mem [frameW];

  logic [dataW-1:0]      tap0;
  logic [dataW-1:0]      tap1;
  logic [8:0][dataW-1:0] win_d;
  logic [8:0][dataW-1:0] win_q;

  assign tap0 = lb0_mem[addr];
  assign tap1 = lb1_mem[addr];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb1_mem[addr] <= tap0;
      lb0_mem[addr] <= din;
    end
  end

  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = tap1;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = tap0;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = din;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign win = win_q;

endmodule

// File: rtl/dog_extrema_detect.sv
// dog_extrema_detect: 3x3x3 scale-space extremum detector.
// Ports:
//   pixClk, rst_n (sync, active-low)
//   en      - pixel accept qualifier; sof marks pixel (0,0)
//   dogIn0/1/2 - signed DoG samples for scales s-1, s, s+1
//   kpValid - one-cycle keypoint pulse; kpX/kpY/kpIsMax/kpVal describe it
//             and hold their value between pulses
// Pipeline: A = window + valid (on accept), B = compare bits (free running),
// C = keypoint decision and output registers. Pulse follows edge T+2 when the
// completing pixel is accepted at edge T.
//
// Valid semantics: a pixel moves only on a clock edge with en=1 (and an
// active frame or sof); there is no backpressure, kpValid is a bare pulse.
module dog_extrema_detect
  import dog_extrema_detect_pkg::*;
#(
  parameter int dataW      = DATA_W_DEF,
  parameter int frameW     = FRAME_W_DEF,
  parameter int xW         = 10,
  parameter int yW         = 10,
  parameter int contrastTh = 3
) (
  input  logic                    pixClk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sof,
  input  logic signed [dataW-1:0] dogIn0,
  input  logic signed [dataW-1:0] dogIn1,
  input  logic signed [dataW-1:0] dogIn2,
  output logic                    kpValid,
  output logic [xW-1:0]           kpX,
  output logic [yW-1:0]           kpY,
  output logic                    kpIsMax,
  output logic signed [dataW-1:0] kpVal
);

  localparam int AW = $clog2(frameW);
  localparam logic signed [dataW-1:0] TH_POS = dataW'(contrastTh);
  localparam logic signed [dataW-1:0] TH_NEG = -TH_POS;
  localparam logic [xW-1:0] COL_LAST = xW'(frameW - 1);
  localparam logic [yW-1:0] ROW_MAX  = {yW{1'b1}};

  // counters and frame tracking
  logic [xW-1:0] col_q, col_d, col_cur;
  logic [yW-1:0] row_q, row_d, row_cur;
  logic          frame_active_q, frame_active_d;
  logic          accept;

  // stage A
  logic          valid_a_q, valid_a_d;
  logic [xW-1:0] x_a_q, x_a_d;
  logic [yW-1:0] y_a_q, y_a_d;
  logic [8:0][dataW-1:0] w0, w1, w2;

  // stage B
  logic                    valid_b_q;
  logic [NB_N-1:0]         gt_b_q, gt_b_d;
  logic [NB_N-1:0]         lt_b_q, lt_b_d;
  logic                    cmax_b_q, cmax_b_d;
  logic                    cmin_b_q, cmin_b_d;
  logic [xW-1:0]           x_b_q;
  logic [yW-1:0]           y_b_q;
  logic signed [dataW-1:0] val_b_q;

  // stage C
  logic                    kp_valid_q, kp_valid_d;
  logic [xW-1:0]           kp_x_q, kp_x_d;
  logic [yW-1:0]           kp_y_q, kp_y_d;
  logic                    kp_is_max_q, kp_is_max_d;
  logic signed [dataW-1:0] kp_val_q, kp_val_d;

  logic signed [dataW-1:0] cen;
  logic signed [dataW-1:0] nb [NB_N];
  logic                    is_max, is_min;

  // Pixels before the first sof are ignored entirely. sof forces (0,0)
  // regardless of where the counters were.
  always_comb begin
    accept         = en && (sof || frame_active_q);
    col_cur        = sof ? '0 : col_q;
    row_cur        = sof ? '0 : row_q;
    frame_active_d = frame_active_q || (en && sof);
    col_d          = col_q;
    row_d          = row_q;
    valid_a_d      = 1'b0;
    x_a_d          = x_a_q;
    y_a_d          = y_a_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_MAX) ? row_cur : row_cur + yW'(1);
      end else begin
        col_d = col_cur + xW'(1);
        row_d = row_cur;
      end
      // Window is complete only once two full columns and rows precede it;
      // this also keeps windows from wrapping across lines.
      valid_a_d = (col_cur >= xW'(2)) && (row_cur >= yW'(2));
      x_a_d     = col_cur - xW'(1);
      y_a_d     = row_cur - yW'(1);
    end
  end

  dog_line_window #(.dataW(dataW), .frameW(frameW)) u_win0 (
    .clk(pixClk), .shift_en(accept), .addr(col_cur[AW-1:0]),
    .din(dogIn0), .win(w0)
  );
  dog_line_window #(.dataW(dataW), .frameW(frameW)) u_win1 (
    .clk(pixClk), .shift_en(accept), .addr(col_cur[AW-1:0]),
    .din(dogIn1), .win(w1)
  );
  dog_line_window #(.dataW(dataW), .frameW(frameW)) u_win2 (
    .clk(pixClk), .shift_en(accept), .addr(col_cur[AW-1:0]),
    .din(dogIn2), .win(w2)
  );

  // Gather the 26 neighbours: both outer scales whole, centre scale minus
  // its own centre tap (index 4).
  always_comb begin
    cen = w1[4];
    for (int i = 0; i < 9; i++) begin
      nb[i]     = w0[i];
      nb[9 + i] = w2[i];
    end
    for (int i = 0; i < 4; i++) nb[18 + i] = w1[i];
    for (int i = 5; i < 9; i++) nb[17 + i] = w1[i];
    for (int i = 0; i < NB_N; i++) begin
      gt_b_d[i] = cen > nb[i];
      lt_b_d[i] = cen < nb[i];
    end
    cmax_b_d = cen > TH_POS;
    cmin_b_d = cen < TH_NEG;
  end

  always_comb begin
    is_max      = gt26(gt_b_q) && cmax_b_q;
    is_min      = lt26(lt_b_q) && cmin_b_q;
    kp_valid_d  = valid_b_q && (is_max || is_min);
    kp_x_d      = kp_x_q;
    kp_y_d      = kp_y_q;
    kp_is_max_d = kp_is_max_q;
    kp_val_d    = kp_val_q;
    if (kp_valid_d) begin
      kp_x_d      = x_b_q;
      kp_y_d      = y_b_q;
      kp_is_max_d = is_max;
      kp_val_d    = val_b_q;
    end
  end

  always_ff @(posedge pixClk) begin
    if (!rst_n) begin
      col_q          <= '0;
      row_q          <= '0;
      frame_active_q <= 1'b0;
      valid_a_q      <= 1'b0;
      x_a_q          <= '0;
      y_a_q          <= '0;
      valid_b_q      <= 1'b0;
      gt_b_q         <= '0;
      lt_b_q         <= '0;
      cmax_b_q       <= 1'b0;
      cmin_b_q       <= 1'b0;
      x_b_q          <= '0;
      y_b_q          <= '0;
      val_b_q        <= '0;
      kp_valid_q     <= 1'b0;
      kp_x_q         <= '0;
      kp_y_q         <= '0;
      kp_is_max_q    <= 1'b0;
      kp_val_q       <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      frame_active_q <= frame_active_d;
      valid_a_q      <= valid_a_d;
      x_a_q          <= x_a_d;
      y_a_q          <= y_a_d;
      // stage B runs every cycle; valid_a is a one-shot so holding the
      // window during en gaps cannot re-issue it
      valid_b_q      <= valid_a_q;
      gt_b_q         <= gt_b_d;
      lt_b_q         <= lt_b_d;
      cmax_b_q       <= cmax_b_d;
      cmin_b_q       <= cmin_b_d;
      x_b_q          <= x_a_q;
      y_b_q          <= y_a_q;
      val_b_q        <= cen;
      kp_valid_q     <= kp_valid_d;
      kp_x_q         <= kp_x_d;
      kp_y_q         <= kp_y_d;
      kp_is_max_q    <= kp_is_max_d;
      kp_val_q       <= kp_val_d;
    end
  end

  assign kpValid = kp_valid_q;
  assign kpX     = kp_x_q;
  assign kpY     = kp_y_q;
  assign kpIsMax = kp_is_max_q;
  assign kpVal   = kp_val_q;

endmodule

// File: tb/tb_dog_extrema_detect.sv
// Directed bench for dog_extrema_detect with 8-pixel lines.
module tb_dog_extrema_detect;

  localparam int FW = 8;
  localparam int NR = 6;

  logic              pixClk;
  logic              rst_n;
  logic              en;
  logic              sof;
  logic signed [7:0] dogIn0, dogIn1, dogIn2;
  logic              kpValid;
  logic [9:0]        kpX;
  logic [9:0]        kpY;
  logic              kpIsMax;
  logic signed [7:0] kpVal;

  dog_extrema_detect #(
    .dataW(8), .frameW(FW), .xW(10), .yW(10), .contrastTh(3)
  ) dut (
    .pixClk(pixClk), .rst_n(rst_n), .en(en), .sof(sof),
    .dogIn0(dogIn0), .dogIn1(dogIn1), .dogIn2(dogIn2),
    .kpValid(kpValid), .kpX(kpX), .kpY(kpY), .kpIsMax(kpIsMax), .kpVal(kpVal)
  );

  // clock/reset
  initial pixClk = 1'b0;
  always #5 pixClk = ~pixClk;

  int cyc = 0;
  always @(posedge pixClk) cyc <= cyc + 1;

  // images
  logic signed [7:0] img0 [NR][FW];
  logic signed [7:0] img1 [NR][FW];
  logic signed [7:0] img2 [NR][FW];

  int checks = 0;
  int errors = 0;
  int t54 = 0;

  // pulse monitor, sampled on the falling edge
  int pulse_cnt = 0;
  int last_x = 0, last_y = 0, last_max = 0, last_val = 0, last_cyc = 0;
  always @(negedge pixClk) begin
    if (kpValid === 1'b1) begin
      pulse_cnt++;
      last_x   = int'(kpX);
      last_y   = int'(kpY);
      last_max = int'(kpIsMax);
      last_val = int'($signed(kpVal));
      last_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_img();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < FW; c++) begin
        img0[r][c] = 8'sd0;
        img1[r][c] = 8'sd0;
        img2[r][c] = 8'sd0;
      end
  endtask

  // Drives npix pixels in raster order; toggle inserts an en=0 cycle after
  // each pixel. Records the accepting edge of pixel (5,4) in t54.
  task automatic send_frame(input int npix, input bit use_sof,
                            input bit toggle, input int flush);
    int x;
    int y;
    for (int p = 0; p < npix; p++) begin
      x = p % FW;
      y = p / FW;
      @(negedge pixClk);
      en     = 1'b1;
      sof    = use_sof && (p == 0);
      dogIn0 = img0[y][x];
      dogIn1 = img1[y][x];
      dogIn2 = img2[y][x];
      if (x == 5 && y == 4) t54 = cyc + 1;
      if (toggle) begin
        @(negedge pixClk);
        en  = 1'b0;
        sof = 1'b0;
      end
    end
    @(negedge pixClk);
    en = 1'b0; sof = 1'b0;
    dogIn0 = '0; dogIn1 = '0; dogIn2 = '0;
    repeat (flush) @(negedge pixClk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sof = 1'b0;
    dogIn0 = '0; dogIn1 = '0; dogIn2 = '0;
    clear_img();
    repeat (3) @(negedge pixClk);
    rst_n = 1'b1;

    // reset state, then a peaked frame without sof must be ignored
    chk("rst_kpValid", int'(kpValid), 0);
    chk("rst_kpX", int'(kpX), 0);
    chk("rst_kpY", int'(kpY), 0);
    chk("rst_kpIsMax", int'(kpIsMax), 0);
    chk("rst_kpVal", int'($signed(kpVal)), 0);
    img1[3][4] = 8'sd20;
    pulse_cnt = 0;
    send_frame(NR * FW, 1'b0, 1'b0, 6);
    chk("nosof_pulses", pulse_cnt, 0);
    chk("nosof_kpX", int'(kpX), 0);

    // maximum
    pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("max_pulses", pulse_cnt, 1);
    chk("max_x", last_x, 4);
    chk("max_y", last_y, 3);
    chk("max_ismax", last_max, 1);
    chk("max_val", last_val, 20);
    chk("max_latency", last_cyc, t54 + 2);
    chk("max_hold_x", int'(kpX), 4);

    // minimum
    clear_img(); img1[3][4] = -8'sd20; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("min_pulses", pulse_cnt, 1);
    chk("min_ismax", last_max, 0);
    chk("min_val", last_val, -20);

    // contrast threshold is strict
    clear_img(); img1[3][4] = 8'sd3; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("th3_pulses", pulse_cnt, 0);
    clear_img(); img1[3][4] = 8'sd4; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("th4_pulses", pulse_cnt, 1);
    chk("th4_val", last_val, 4);

    // tie in scale above, larger value in scale below
    clear_img(); img1[3][4] = 8'sd20; img2[2][3] = 8'sd20; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("tie_pulses", pulse_cnt, 0);
    clear_img(); img1[3][4] = 8'sd20; img0[3][4] = 8'sd25; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("cross_pulses", pulse_cnt, 0);

    // borders
    clear_img(); img1[3][0] = 8'sd20; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("border_c0", pulse_cnt, 0);
    clear_img(); img1[3][7] = 8'sd20; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("border_c7", pulse_cnt, 0);
    clear_img(); img1[0][3] = 8'sd20; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("border_r0", pulse_cnt, 0);

    // flow control: en toggling 1,0
    clear_img(); img1[3][4] = 8'sd20; pulse_cnt = 0;
    send_frame(NR * FW, 1'b1, 1'b1, 6);
    chk("flow_pulses", pulse_cnt, 1);
    chk("flow_x", last_x, 4);
    chk("flow_y", last_y, 3);
    chk("flow_latency", last_cyc, t54 + 2);

    // sof restart in row 5, then a clean frame
    clear_img(); img1[5][4] = 8'sd20; pulse_cnt = 0;
    send_frame(5 * FW + 6, 1'b1, 1'b0, 0);
    clear_img(); img1[3][4] = 8'sd20;
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("midsof_pulses", pulse_cnt, 1);
    chk("midsof_x", last_x, 4);
    chk("midsof_y", last_y, 3);
    chk("midsof_latency", last_cyc, t54 + 2);

    // reset one cycle after accepting (5,4) kills the in-flight window
    pulse_cnt = 0;
    send_frame(4 * FW + 6, 1'b1, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge pixClk);
    rst_n = 1'b1;
    repeat (8) @(negedge pixClk);
    chk("rstmid_pulses", pulse_cnt, 0);
    chk("rstmid_kpX", int'(kpX), 0);
    send_frame(NR * FW, 1'b1, 1'b0, 6);
    chk("recover_pulses", pulse_cnt, 1);
    chk("recover_latency", last_cyc, t54 + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
